// File: rtl/seq_detect_run.sv
// Run-length detector: flags RUN_LEN consecutive equal valid bits on w, with polarity/overlap control.
// Define SEQ_DETECT_RUN_LEN_OUT_EN to expose the current run count on run_len.
module seq_detect_run #(
    parameter int RUN_LEN = 4,
    parameter int CNT_W   = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         w,
    input  logic                         w_valid,
    input  logic                         clear,
    input  logic [1:0]                   mode,
    input  logic                         overlap,
    output logic                         z,
    output logic                         z_one,
    output logic                         z_zero,
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
    output logic [$clog2(RUN_LEN+1)-1:0] run_len,
`endif
    output logic [CNT_W-1:0]             match_cnt
);

    localparam int RC_W = $clog2(RUN_LEN + 1);
    localparam logic [RC_W-1:0] RUN_MAX = RC_W'(RUN_LEN);

    generate
        if (RUN_LEN < 2 || RUN_LEN > 255) begin : g_bad_run_len
            $error("seq_detect_run: RUN_LEN must be in 2..255");
        end
    endgenerate

    logic [RC_W-1:0]  run_cnt_q, run_cnt_d;
    logic             last_bit_q, last_bit_d;
    logic             z_q, z_d, z_one_q, z_one_d, z_zero_q, z_zero_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RC_W-1:0]  run_nxt;
    logic             pol_en, hit;

    always_comb begin
        run_cnt_d  = run_cnt_q;
        last_bit_d = last_bit_q;
        cnt_d      = cnt_q;
        z_d        = 1'b0;
        z_one_d    = 1'b0;
        z_zero_d   = 1'b0;
        run_nxt    = run_cnt_q;
        pol_en     = 1'b0;
        hit        = 1'b0;
        if (clear) begin
            run_cnt_d = '0;
            cnt_d     = '0;
        end else if (w_valid) begin
            if (run_cnt_q == '0 || w != last_bit_q) begin
                run_nxt    = RC_W'(1);
                last_bit_d = w;
            end else if (run_cnt_q == RUN_MAX) begin
                run_nxt = RUN_MAX;
            end else begin
                run_nxt = run_cnt_q + RC_W'(1);
            end
            pol_en = w ? mode[0] : mode[1];
            hit    = (run_nxt == RUN_MAX) && pol_en;
            // A disabled-polarity run only saturates; the restart is tied to an actual hit.
            run_cnt_d = (hit && !overlap) ? '0 : run_nxt;
            z_d       = hit;
            z_one_d   = hit & w;
            z_zero_d  = hit & ~w;
            if (hit && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run_cnt_q  <= '0;
            last_bit_q <= 1'b0;
            z_q        <= 1'b0;
            z_one_q    <= 1'b0;
            z_zero_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            run_cnt_q  <= run_cnt_d;
            last_bit_q <= last_bit_d;
            z_q        <= z_d;
            z_one_q    <= z_one_d;
            z_zero_q   <= z_zero_d;
            cnt_q      <= cnt_d;
        end
    end

    assign z         = z_q;
    assign z_one     = z_one_q;
    assign z_zero    = z_zero_q;
    assign match_cnt = cnt_q;
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
    assign run_len   = run_cnt_q;
`endif

endmodule

// File: tb/tb_seq_detect_run.sv
// Directed bench for seq_detect_run (RUN_LEN=4); a second instance with CNT_W=2 covers counter saturation.
module tb_seq_detect_run;

    logic       clk = 1'b0;
    logic       reset_n, w, w_valid, clear, overlap;
    logic [1:0] mode;
    logic       z, z_one, z_zero, z2, z2_one, z2_zero;
    logic [7:0] match_cnt;
    logic [1:0] match_cnt2;
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
    logic [2:0] run_len, run_len2;
`endif
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    seq_detect_run #(.RUN_LEN(4), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .w(w), .w_valid(w_valid), .clear(clear),
        .mode(mode), .overlap(overlap), .z(z), .z_one(z_one), .z_zero(z_zero),
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
        .run_len(run_len),
`endif
        .match_cnt(match_cnt)
    );

    seq_detect_run #(.RUN_LEN(4), .CNT_W(2)) dut2 (
        .clk(clk), .reset_n(reset_n), .w(w), .w_valid(w_valid), .clear(clear),
        .mode(mode), .overlap(overlap), .z(z2), .z_one(z2_one), .z_zero(z2_zero),
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
        .run_len(run_len2),
`endif
        .match_cnt(match_cnt2)
    );

    // Drive one cycle of input, then return 1 time unit after the sampling edge.
    task automatic tick(input logic b, input logic v);
        w = b; w_valid = v;
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; w = 1'b0; w_valid = 1'b0; clear = 1'b0; mode = 2'b11; overlap = 1'b0;
        #12;
        total++;
        if (z !== 1'b0 || z_one !== 1'b0 || z_zero !== 1'b0 || match_cnt !== 8'd0) begin
            bad++; $display("FAIL reset: z=%b z1=%b z0=%b cnt=%0d required all 0", z, z_one, z_zero, match_cnt);
        end
`ifdef SEQ_DETECT_RUN_LEN_OUT_EN
        total++;
        if (run_len !== 3'd0) begin bad++; $display("FAIL reset_run_len: got %0d required 0", run_len); end
`endif
        reset_n = 1'b1;
    endtask

    task automatic test_zeros;
        int pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(1'b0, 1'b1); pulses += int'(z); end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL zeros_early: got %0d pulses required 0", pulses); end
        tick(1'b0, 1'b1);
        total++;
        if (z !== 1'b1 || z_zero !== 1'b1 || z_one !== 1'b0 || match_cnt !== 8'd1) begin
            bad++; $display("FAIL zeros_hit: z=%b z0=%b z1=%b cnt=%0d required 1 1 0 1", z, z_zero, z_one, match_cnt);
        end
        tick(1'b0, 1'b0);
        total++;
        if (z !== 1'b0 || z_zero !== 1'b0) begin bad++; $display("FAIL zeros_one_cycle: z=%b z0=%b required 0 0", z, z_zero); end
    endtask

    task automatic test_mixed;
        logic [7:0] pat;
        int pulses = 0;
        pat = 8'b0110_1111;
        for (int i = 7; i >= 1; i--) begin tick(pat[i], 1'b1); pulses += int'(z); end
        total++;
        if (pulses != 0) begin bad++; $display("FAIL mixed_no_z: got %0d pulses required 0", pulses); end
        tick(pat[0], 1'b1);
        total++;
        if (z_one !== 1'b1 || z_zero !== 1'b0 || match_cnt !== 8'd2) begin
            bad++; $display("FAIL mixed_hit: z1=%b z0=%b cnt=%0d required 1 0 2", z_one, z_zero, match_cnt);
        end
    endtask

    task automatic test_overlap;
        int pulses;
        logic [5:0] zs;
        overlap = 1'b1;
        for (int i = 0; i < 6; i++) begin tick(1'b1, 1'b1); zs[i] = z; end
        total++;
        if (zs !== 6'b111000 || match_cnt !== 8'd5) begin
            bad++; $display("FAIL overlap6: z history=%b cnt=%0d required 111000 5", zs, match_cnt);
        end
        tick(1'b0, 1'b1);
        overlap = 1'b0; pulses = 0;
        for (int i = 0; i < 6; i++) begin tick(1'b1, 1'b1); pulses += int'(z); end
        total++;
        if (pulses != 1 || match_cnt !== 8'd6) begin
            bad++; $display("FAIL nonoverlap6: got %0d pulses cnt=%0d required 1 6", pulses, match_cnt);
        end
        tick(1'b0, 1'b1);
        pulses = 0;
        for (int i = 0; i < 8; i++) begin tick(1'b1, 1'b1); pulses += int'(z); end
        total++;
        if (pulses != 2 || match_cnt !== 8'd8) begin
            bad++; $display("FAIL nonoverlap8: got %0d pulses cnt=%0d required 2 8", pulses, match_cnt);
        end
    endtask

    task automatic test_mode;
        int pulses = 0;
        mode = 2'b01;
        for (int i = 0; i < 5; i++) begin tick(1'b0, 1'b1); pulses += int'(z); end
        total++;
        if (pulses != 0 || match_cnt !== 8'd8) begin
            bad++; $display("FAIL mode_zeros_masked: got %0d pulses cnt=%0d required 0 8", pulses, match_cnt);
        end
        // Saturated zero run must still be at RUN_LEN, so enabling zeros hits on the very next 0.
        mode = 2'b11;
        tick(1'b0, 1'b1);
        total++;
        if (z_zero !== 1'b1 || match_cnt !== 8'd9) begin
            bad++; $display("FAIL mode_saturated_run: z0=%b cnt=%0d required 1 9", z_zero, match_cnt);
        end
        mode = 2'b01; pulses = 0;
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1); pulses += int'(z);
            if (i == 3) begin
                total++;
                if (z_one !== 1'b1) begin bad++; $display("FAIL mode_ones_hit: z1=%b required 1", z_one); end
            end
        end
        total++;
        if (pulses != 1 || match_cnt !== 8'd10) begin
            bad++; $display("FAIL mode_ones_count: got %0d pulses cnt=%0d required 1 10", pulses, match_cnt);
        end
        mode = 2'b11;
    endtask

    task automatic test_valid_clear;
        int pulses = 0;
        tick(1'b0, 1'b1);
        tick(1'b1, 1'b1); tick(1'b1, 1'b1);
        tick(1'b0, 1'b0);
        total++;
        if (z !== 1'b0) begin bad++; $display("FAIL valid_gap_z: got %b required 0", z); end
        tick(1'b1, 1'b1);
        total++;
        if (z !== 1'b0) begin bad++; $display("FAIL valid_third: got %b required 0", z); end
        tick(1'b1, 1'b1);
        total++;
        if (z_one !== 1'b1 || match_cnt !== 8'd11) begin
            bad++; $display("FAIL valid_hit: z1=%b cnt=%0d required 1 11", z_one, match_cnt);
        end
        tick(1'b1, 1'b1); pulses += int'(z);
        tick(1'b1, 1'b1); pulses += int'(z);
        clear = 1'b1; tick(1'b1, 1'b1); clear = 1'b0; pulses += int'(z);
        total++;
        if (match_cnt !== 8'd0 || match_cnt2 !== 2'd0) begin
            bad++; $display("FAIL clear_cnt: cnt=%0d cnt2=%0d required 0 0", match_cnt, match_cnt2);
        end
        tick(1'b1, 1'b1); pulses += int'(z);
        tick(1'b1, 1'b1); pulses += int'(z);
        total++;
        if (pulses != 0 || match_cnt !== 8'd0) begin
            bad++; $display("FAIL clear_no_match: got %0d pulses cnt=%0d required 0 0", pulses, match_cnt);
        end
    endtask

    task automatic test_saturate_async_reset;
        logic [1:0] exp_cnt [5];
        exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        overlap = 1'b1;
        tick(1'b0, 1'b1);
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick(1'b1, 1'b1);
            total++;
            if (match_cnt2 !== exp_cnt[i] || z2 !== 1'b1) begin
                bad++; $display("FAIL sat_cnt%0d: cnt2=%0d z2=%b required %0d 1", i, match_cnt2, z2, exp_cnt[i]);
            end
        end
        total++;
        if (match_cnt !== 8'd5) begin bad++; $display("FAIL sat_wide_cnt: got %0d required 5", match_cnt); end
        #2 reset_n = 1'b0;
        #1;
        total++;
        if (z !== 1'b0 || z_one !== 1'b0 || match_cnt !== 8'd0 || z2 !== 1'b0 || match_cnt2 !== 2'd0) begin
            bad++; $display("FAIL async_reset: z=%b z1=%b cnt=%0d z2=%b cnt2=%0d required all 0",
                            z, z_one, match_cnt, z2, match_cnt2);
        end
        #1 reset_n = 1'b1;
        tick(1'b1, 1'b1);
        total++;
        if (z !== 1'b0 || match_cnt !== 8'd0) begin
            bad++; $display("FAIL post_reset_run: z=%b cnt=%0d required 0 0", z, match_cnt);
        end
    endtask

    initial begin
        test_reset;
        test_zeros;
        test_mixed;
        test_overlap;
        test_mode;
        test_valid_clear;
        test_saturate_async_reset;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_detect_run.md
Name: seq_detect_run

Overview:
- Parametrised successor of the fixed 4-bit 1111/0000 sequence detector.
- Detects RUN_LEN consecutive equal bits on serial input w.
- Adds runtime polarity select, overlap/non-overlap mode, an input-valid qualifier, a synchronous clear and a saturating match counter.
- Sits on the serial bit stream ahead of framing/alarm logic. Output is a registered (Moore) pulse.

Parameters:
- RUN_LEN, 4: consecutive equal bits required for a match. Legal range is 2..255. Elaboration fails outside this range.
- CNT_W, 8: width of the match counter.

Ports:
- clk, input, 1: rising-edge clock.
- reset_n, input, 1: asynchronous active-low reset.
- w, input, 1: serial data bit.
- w_valid, input, 1: w is sampled only in cycles where w_valid=1.
- clear, input, 1: synchronous clear of run state, outputs and counter.
- mode, input, 2: polarity enable. 00 = none, 01 = ones, 10 = zeros, 11 = both.
- overlap, input, 1: 1 = overlapping detection, 0 = non-overlapping.
- z, output, 1: match pulse, registered.
- z_one, output, 1: the match was a run of 1s.
- z_zero, output, 1: the match was a run of 0s.
- match_cnt, output, CNT_W: saturating count of matches.

Behaviour:
- Reset (reset_n=0, asynchronous): run_cnt=0, last_bit=0, z=z_one=z_zero=0, match_cnt=0.
- Release of reset is synchronous to clk.
- Internal state:
  - last_bit (1b).
  - run_cnt, width $clog2(RUN_LEN+1). A value of 0 means no history.
- Per rising edge, priority is clear > w_valid.
- clear=1: run_cnt=0, z/z_one/z_zero=0, match_cnt=0. w is ignored that cycle.
- w_valid=0: run state is held; z, z_one and z_zero go to 0.
- w_valid=1, with b=w:
  - If run_cnt==0 or b!=last_bit: run_cnt_next=1, last_bit=b.
  - Otherwise: run_cnt_next = min(run_cnt+1, RUN_LEN).
  - hit = (run_cnt_next==RUN_LEN) AND polarity of b enabled by mode.
  - z=hit, z_one=hit&b, z_zero=hit&~b, all registered on this edge. Latency is z high in the cycle after the edge that samples the RUN_LEN-th bit.
  - overlap=1: run_cnt saturates at RUN_LEN. Each further equal valid bit raises z again, so z stays high across the run.
  - overlap=0: on hit, run_cnt_next is forced to 0. The next match needs RUN_LEN fresh equal bits.
  - A run that reaches RUN_LEN while its polarity is disabled by mode does NOT reset run_cnt in either overlap setting. It simply saturates.
- mode and overlap are sampled every edge. Changing them mid-run does not clear run state.
- match_cnt increments by 1 on each hit. It saturates at 2^CNT_W-1 and never wraps.
- Invalid bits (w_valid=0) do not break a run. The run continues with the next valid bit.
- z_one and z_zero are never both high.

Optional Feature:
- Macro SEQ_DETECT_RUN_LEN_OUT_EN.
- Defined: adds output port run_len, width $clog2(RUN_LEN+1). It carries the current registered run_cnt, for debug/monitoring. Reset value is 0, and it is cleared by clear.
- Undefined: the port is absent. Behaviour is otherwise identical.

Test Plan:
- Reset then 0000, with RUN_LEN=4, mode=11, overlap=0, w_valid=1 → z=1, z_zero=1 for exactly one cycle after the 4th bit; match_cnt=1.
- Stream 0,1,1,0 then 1,1,1,1 → no z during the mixed bits; z_one pulses once after the 4th 1; match_cnt increments by 1.
- overlap=1, six consecutive 1s → z high for 3 consecutive cycles (after bits 4, 5, 6). With overlap=0, the same stream gives 1 pulse. With eight 1s and overlap=0, it gives 2 pulses.
- mode=01, stream 0000 → no z and match_cnt unchanged. Then a 1 followed by 1111 → z_one pulses.
- w_valid toggling: 1,1,(invalid),1,1 → z pulses after the 4th valid 1. z=0 in the invalid cycle. Then assert clear mid-run (1,1,clear,1,1) → no match.
- CNT_W=2, 5 matches → match_cnt goes 1, 2, 3, 3, 3. Then assert reset_n=0 asynchronously mid-run → all outputs 0 immediately, before the next clock edge.
